// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and default width.
package alu_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file with two async read ports and one sync write port; r0 reads as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int NREGS = 4,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] raddr1,
    input  logic [RW-1:0] raddr2,
    output logic [W-1:0]  rdata1,
    output logic [W-1:0]  rdata2,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] regs [NREGS];

    // Reset takes priority so a write landing on the reset edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues register-level commands to an external combinational ALU and writes results back.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter  int W     = W_DEFAULT,
    parameter  int NREGS = 4,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rs1,
    input  logic [RW-1:0] cmd_rs2,
    input  logic          cmd_imm_en,
    input  logic [W-1:0]  cmd_imm,
    output logic [2:0]    alu_opcode,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_y,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic [RW-1:0] rsp_rd,
    output logic          rsp_zero
);

    seq_state_t    state;
    seq_state_t    next_state;
    logic          accept;
    logic          wb_en;
    logic [RW-1:0] rd_q;
    logic [W-1:0]  rdata1;
    logic [W-1:0]  rdata2;

    assign accept = cmd_valid & cmd_ready;
    assign wb_en  = (state == EXEC);

    alu_regfile #(
        .W     (W),
        .NREGS (NREGS),
        .RW    (RW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (cmd_rs1),
        .raddr2 (cmd_rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (wb_en),
        .waddr  (rd_q),
        .wdata  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // cmd_ready is masked by rst so nothing is taken during the reset cycle itself.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operands are held after EXEC; the response fields change only on the EXEC edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            rsp_data   <= '0;
            rsp_rd     <= '0;
            rsp_zero   <= 1'b1;
        end else begin
            if (accept) begin
                alu_opcode <= cmd_op;
                alu_a      <= rdata1;
                alu_b      <= cmd_imm_en ? cmd_imm : rdata2;
                rd_q       <= cmd_rd;
            end
            if (state == EXEC) begin
                rsp_data <= alu_y;
                rsp_rd   <= rd_q;
                rsp_zero <= (alu_y == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: driver pushes model-predicted responses, monitor pops and compares them.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [1:0] rd;
        logic       zero;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_rd;
    logic       rsp_zero;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   stallReq = 0;
    exp_t sbq[$];
    int   mdl[4];

    alu_cmd_sequencer #(.W(8), .NREGS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_y = '0;
        case (alu_opcode)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a + ~alu_b + 8'd1;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_NAND: alu_y = ~(alu_a & alu_b);
            OP_NOR:  alu_y = ~(alu_a | alu_b);
            default: alu_y = ~(alu_a ^ alu_b);
        endcase
    end

    function automatic int refOp(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a ^ b;
            4: return a | b;
            5: return 255 - (a & b);
            6: return 255 - (a | b);
            default: return 255 - (a ^ b);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic immEn, input logic [7:0] imm);
        int   waitc;
        int   a;
        int   b;
        int   y;
        exp_t e;
        @(negedge clk);
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm_en = immEn;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_ready !== 1'b1) begin
            checkOutput("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        checkOutput("rsp_idle_at_accept", rsp_valid, 0);
        a = mdl[rs1];
        b = immEn ? int'(imm) : mdl[rs2];
        y = refOp(int'(op), a, b);
        if (rd != 0) mdl[rd] = y;
        e.data = y[7:0];
        e.rd   = rd;
        e.zero = (y == 0);
        e.acc  = cyc;
        sbq.push_back(e);
        @(negedge clk);
        checkOutput("exec_opcode", alu_opcode, op);
        checkOutput("exec_alu_a", alu_a, a);
        checkOutput("exec_alu_b", alu_b, b);
    endtask

    // Monitor: pops on each new response, checks latency, hold stability and ready backpressure.
    initial begin : monitor
        exp_t       e;
        logic       inResp;
        logic       expectDrop;
        int         stallCnt;
        logic [7:0] hData;
        logic [1:0] hRd;
        logic       hZero;
        inResp = 0;
        expectDrop = 0;
        stallCnt = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                inResp = 0;
                expectDrop = 0;
                stallCnt = 0;
                rsp_ready = 1'b1;
            end else begin
                if (expectDrop) checkOutput("rsp_valid_drop", rsp_valid, 0);
                expectDrop = 0;
                if (rsp_valid === 1'b1) begin
                    checkOutput("cmd_ready_in_resp", cmd_ready, 0);
                    if (!inResp) begin
                        if (sbq.size() == 0) begin
                            checkOutput("unexpected_rsp", 1, 0);
                        end else begin
                            e = sbq.pop_front();
                            checkOutput("rsp_data", rsp_data, e.data);
                            checkOutput("rsp_rd", rsp_rd, e.rd);
                            checkOutput("rsp_zero", rsp_zero, e.zero);
                            checkOutput("rsp_latency", cyc - e.acc, 2);
                        end
                        hData = rsp_data;
                        hRd   = rsp_rd;
                        hZero = rsp_zero;
                        if (stallReq != 0) begin
                            stallCnt = 5;
                            stallReq = 0;
                        end
                    end else begin
                        checkOutput("hold_data", rsp_data, hData);
                        checkOutput("hold_rd", rsp_rd, hRd);
                        checkOutput("hold_zero", rsp_zero, hZero);
                    end
                end
                if (stallCnt > 0) begin
                    rsp_ready = 1'b0;
                    stallCnt--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                inResp     = (rsp_valid === 1'b1) && !rsp_ready;
                expectDrop = (rsp_valid === 1'b1) && rsp_ready;
            end
        end
    end

    initial begin : driver
        int waitc;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_rd", rsp_rd, 0);
        checkOutput("reset_rsp_zero", rsp_zero, 1);
        checkOutput("reset_alu_opcode", alu_opcode, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_alu_b", alu_b, 0);
        rst = 1'b0;
        #1 checkOutput("ready_after_reset", cmd_ready, 1);

        $display("[TB] load and add");
        applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F);
        applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'hF0);
        applyStimulus(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);

        $display("[TB] sub wrap");
        applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00);
        applyStimulus(OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
        applyStimulus(OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00);

        $display("[TB] logic ops");
        applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hAA);
        applyStimulus(OP_XOR, 2'd2, 2'd1, 2'd0, 1'b1, 8'hAA);
        applyStimulus(OP_XNOR, 2'd3, 2'd1, 2'd0, 1'b1, 8'h55);
        applyStimulus(OP_NOR, 2'd3, 2'd1, 2'd0, 1'b1, 8'h55);

        $display("[TB] r0 discard");
        applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h33);
        applyStimulus(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00);

        $display("[TB] backpressure");
        stallReq = 1;
        applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h5A);
        applyStimulus(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);

        $display("[TB] reset mid-operation");
        applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7E);
        rst = 1'b1;
        cmd_valid = 1'b0;
        if (sbq.size() > 0) void'(sbq.pop_back());
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        #1 checkOutput("rst_cycle_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
        checkOutput("rst_mid_cmd_ready", cmd_ready, 1);
        applyStimulus(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00);

        $display("[TB] random commands");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        cmd_valid = 1'b0;
        waitc = 0;
        while ((sbq.size() != 0 || rsp_valid === 1'b1) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (sbq.size() != 0 || rsp_valid === 1'b1) checkOutput("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
